// File: rtl/bin2bcd_display_if.sv
// Bundle between the multiplier side and the BCD converter/display block.
// master drives data/load and observes the results; slave is the converter.
interface bin2bcd_display_if #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
);
    logic [WIDTH-1:0]    data;
    logic                load;
    logic                busy;
    logic                valid;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;

    modport master (output data, load, input busy, valid, bcd, an, seg);
    modport slave  (input data, load, output busy, valid, bcd, an, seg);
endinterface

// File: rtl/bin2bcd_display.sv
// Captures a binary value on a load rising edge, converts it to packed BCD one bit
// per clock (double dabble), and scans it onto a multiplexed active-low 7-seg display.
module bin2bcd_display #(
    parameter int WIDTH       = 6,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              init,
    bin2bcd_display_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {IDLE, CONV} state_t;

    state_t              state_r;
    logic                load_q_r;
    logic [WIDTH-1:0]    bin_sr_r;
    logic [4*DIGITS-1:0] scratch_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic                valid_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [REF_W-1:0]    refresh_r;
    logic [IDX_W-1:0]    idx_r;
    logic [DIGITS-1:0]   an_r;
    logic [6:0]          seg_r;

    logic                start_s;
    logic [4*DIGITS-1:0] adj_s;
    logic [4*DIGITS-1:0] scratch_nxt_s;
    logic [WIDTH-1:0]    bin_nxt_s;
    logic [3:0]          digit_s;
    logic                upper_nz_s;
    logic [DIGITS-1:0]   an_nxt_s;
    logic [6:0]          seg_nxt_s;

    // Each digit >= 5 gets +3 independently; no carry crosses digit boundaries.
    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = (v[4*d +: 4] >= 4'd5) ? (v[4*d +: 4] + 4'd3) : v[4*d +: 4];
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign start_s = bus.load & ~load_q_r & (state_r == IDLE);

    // One double-dabble step: adjust, then shift {scratch, bin_sr} left by one.
    always_comb begin
        adj_s         = add3(scratch_r);
        scratch_nxt_s = {adj_s[4*DIGITS-2:0], bin_sr_r[WIDTH-1]};
        bin_nxt_s     = bin_sr_r << 1;
    end

    // Conversion FSM with load edge detection and registered status/result.
    always_ff @(posedge clk) begin
        if (init) begin
            state_r   <= IDLE;
            load_q_r  <= 1'b0;
            bin_sr_r  <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            bcd_r     <= '0;
        end else begin
            load_q_r <= bus.load;
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        bin_sr_r  <= bus.data;
                        scratch_r <= '0;
                        cnt_r     <= CNT_W'(WIDTH);
                        valid_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= CONV;
                    end
                end
                CONV: begin
                    scratch_r <= scratch_nxt_s;
                    bin_sr_r  <= bin_nxt_s;
                    cnt_r     <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        bcd_r   <= scratch_nxt_s;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Select the scanned digit and apply leading-zero blanking (digit 0 always shown).
    always_comb begin
        an_nxt_s   = '1;
        seg_nxt_s  = 7'h7F;
        digit_s    = 4'd0;
        upper_nz_s = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            digit_s    = (IDX_W'(d) == idx_r) ? bcd_r[4*d +: 4] : digit_s;
            upper_nz_s = upper_nz_s | ((d >= int'(idx_r)) && (bcd_r[4*d +: 4] != 4'd0));
        end
        if (!valid_r) begin
            an_nxt_s  = '1;
            seg_nxt_s = 7'h7F;
        end else if ((idx_r != '0) && !upper_nz_s) begin
            an_nxt_s  = '1;
            seg_nxt_s = 7'h7F;
        end else begin
            an_nxt_s  = ~(DIGITS'(1) << idx_r);
            seg_nxt_s = seg_decode(digit_s);
        end
    end

    // Refresh timer, digit scan index and registered display drive.
    always_ff @(posedge clk) begin
        if (init) begin
            refresh_r <= '0;
            idx_r     <= '0;
            an_r      <= '1;
            seg_r     <= 7'h7F;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            if (refresh_r == REF_W'(REFRESH_DIV - 1)) begin
                refresh_r <= '0;
                idx_r     <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : (idx_r + IDX_W'(1));
            end else begin
                refresh_r <= refresh_r + REF_W'(1);
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;
    assign bus.bcd   = bcd_r;
    assign bus.an    = an_r;
    assign bus.seg   = seg_r;
endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench: stimulus queues expected BCD, a negedge monitor checks results,
// busy length and every display sample against decimal arithmetic and the segment table.
module tb_bin2bcd_display;
    localparam int WIDTH       = 6;
    localparam int DIGITS      = 2;
    localparam int REFRESH_DIV = 4;

    logic clk = 1'b0;
    logic init;
    always #5 clk = ~clk;

    bin2bcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d > 4'd9) ? 7'h7F : tbl[d];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  bus.busy,  1'b0);
        check({tag, "_valid"}, bus.valid, 1'b0);
        check({tag, "_bcd"},   bus.bcd,   8'h00);
        check({tag, "_an"},    bus.an,    2'b11);
        check({tag, "_seg"},   bus.seg,   7'h7F);
    endtask

    task automatic convert(input int v, input int gap);
        bus.data = WIDTH'(v);
        bus.load = 1'b1;
        exp_q.push_back(to_bcd(v));
        tick(1);
        bus.load = 1'b0;
        bus.data = WIDTH'($urandom);
        tick(WIDTH);
        tick(gap);
    endtask

    // Records whether init was sampled at the most recent rising edge.
    logic init_at_edge = 1'b1;
    initial forever begin
        @(posedge clk);
        init_at_edge = init;
    end

    // Monitor: display outputs reflect the previous cycle's valid/bcd.
    initial begin
        logic       pv, pbusy;
        logic [7:0] pb, last_bcd, e;
        int         busy_cnt;
        pv = 1'b0; pbusy = 1'b0; pb = 8'h00; last_bcd = 8'h00; busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (init_at_edge) begin
                busy_cnt = 0;
                last_bcd = 8'h00;
            end else begin
                if (!pv) begin
                    check("an_invalid", bus.an, 2'b11);
                    check("seg_invalid", bus.seg, 7'h7F);
                end else begin
                    case (bus.an)
                        2'b10: check("seg_units", bus.seg, seg_of(pb[3:0]));
                        2'b01: begin
                            check("tens_shown_nonzero", pb[7:4] != 4'd0, 1'b1);
                            check("seg_tens", bus.seg, seg_of(pb[7:4]));
                        end
                        2'b11: begin
                            check("blank_needs_zero_tens", pb[7:4], 4'd0);
                            check("seg_blank", bus.seg, 7'h7F);
                        end
                        default: check("an_at_most_one_low", bus.an, 2'b10);
                    endcase
                end
                if (bus.busy) begin
                    busy_cnt++;
                    check("bcd_held_during_conv", bus.bcd, last_bcd);
                end else if (pbusy) begin
                    check("busy_length", busy_cnt, WIDTH);
                    check("valid_at_done", bus.valid, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_conversion: got bcd 0x%0h, expected none", bus.bcd);
                    end else begin
                        e = exp_q.pop_front();
                        check("bcd_result", bus.bcd, e);
                        last_bcd = e;
                    end
                    busy_cnt = 0;
                end
            end
            pv    = bus.valid;
            pb    = bus.bcd;
            pbusy = bus.busy;
        end
    end

    initial begin
        logic [1:0] an_s  [0:23];
        logic [6:0] seg_s [0:23];
        int         last_t, ntrans;
        logic       seen;

        init     = 1'b1;
        bus.load = 1'b0;
        bus.data = '0;
        tick(2);
        check_reset_vals("reset");
        init = 1'b0;
        tick(5);
        check_reset_vals("idle");

        convert(42, 1);
        check("bcd_42", bus.bcd, 8'h42);
        convert(63, 1);
        convert(0, 0);

        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.an == 2'b10 && bus.seg == 7'h40) seen = 1'b1;
        end
        check("zero_units_lit", seen, 1'b1);

        convert(42, 2);
        for (int i = 0; i < 24; i++) begin
            an_s[i]  = bus.an;
            seg_s[i] = bus.seg;
            tick(1);
        end
        last_t = -1;
        ntrans = 0;
        for (int i = 0; i < 24; i++) begin
            check("refresh_seg", seg_s[i], (an_s[i] == 2'b10) ? 7'h24 : 7'h19);
            check("refresh_an_legal", (an_s[i] == 2'b10) || (an_s[i] == 2'b01), 1'b1);
            if (i > 0 && an_s[i] != an_s[i-1]) begin
                if (last_t >= 0) check("refresh_period", i - last_t, REFRESH_DIV);
                last_t = i;
                ntrans++;
            end
        end
        check("refresh_toggles", ntrans >= 4, 1'b1);

        bus.data = 6'd9;
        bus.load = 1'b1;
        exp_q.push_back(to_bcd(9));
        tick(1);
        bus.data = 6'd50;
        tick(1);
        bus.load = 1'b0;
        tick(1);
        bus.load = 1'b1;
        tick(17);
        bus.load = 1'b0;
        tick(2);
        check("handshake_bcd", bus.bcd, 8'h09);

        bus.data = 6'd55;
        bus.load = 1'b1;
        exp_q.push_back(to_bcd(55));
        tick(1);
        bus.load = 1'b0;
        tick(2);
        init = 1'b1;
        void'(exp_q.pop_back());
        tick(1);
        check_reset_vals("abort");
        init = 1'b0;
        tick(4);
        check("valid_after_abort", bus.valid, 1'b0);
        convert(37, 2);
        check("bcd_after_abort", bus.bcd, 8'h37);

        for (int i = 0; i < 25; i++) begin
            convert(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
        end

        tick(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2bcd_display.md
Name: bin2bcd_display

Overview:
- Downstream consumer of the 3x3 shift-add multiplier's 6-bit product.
- On each completed multiply (rising edge of the multiplier's done level), captures the product.
- Converts it to packed BCD with a sequential shift-add-3 (double-dabble) loop, one bit per clock.
- Drives a time-multiplexed, active-low 7-segment display from the converted value.

Parameters:
- WIDTH, 6, binary input width. Must satisfy 10^DIGITS > 2^WIDTH; other combinations are unsupported.
- DIGITS, 2, number of BCD digits / display positions.
- REFRESH_DIV, 50000, clock cycles each digit stays lit. Must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- init  input  1  synchronous, active-high reset.
- data  input  WIDTH  binary value to convert (multiplier result).
- load  input  1  conversion request (multiplier done). Level input; only its rising edge triggers.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  bcd holds a completed conversion.
- bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- an  output  DIGITS  anode enables, active-low, at most one low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset: init=1 at a clk edge forces the following values:
  - state IDLE; busy=0; valid=0; bcd=0
  - internal shift/scratch registers 0; load_q=0
  - refresh counter 0; digit index 0
  - an=all 1; seg=7'h7F
- init has priority over every other event, including mid-conversion. A conversion in flight is discarded; valid stays 0.
- Edge detect: load_q <= load every cycle. start = load & ~load_q & (state==IDLE).
  - Rising edges while busy are ignored and not queued.
  - load held high produces exactly one conversion.
  - load already high when init drops triggers one conversion on the first cycle out of reset.
- FSM states: IDLE, CONV.
  - IDLE, on start: bin_sr <= data; scratch <= 0; cnt <= WIDTH; valid <= 0; busy <= 1; go to CONV.
  - CONV, each edge:
    - every scratch digit ≥5 gets +3, using 4-bit arithmetic with no carry between digits;
    - then {scratch, bin_sr} shifts left 1;
    - cnt decrements.
  - CONV, on the edge processing cnt==1: bcd <= final scratch; valid <= 1; busy <= 0; go to IDLE.
- Latency: busy is high for exactly WIDTH cycles. bcd and valid update on the WIDTH-th edge after the start edge.
- bcd holds the previous value during conversion, so the display does not flicker. data changes after capture have no effect.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index advances, wrapping from DIGITS-1 to 0.
- an and seg are registered, updated every cycle from the current index and bcd, so they lag the index by 1 cycle:
  - valid=0: an all 1, seg 7'h7F.
  - Otherwise: an[idx]=0 and all other bits 1, with seg showing the decode of bcd digit idx.
  - Leading-zero blanking: a nonzero-index digit is blanked (an all 1, seg 7'h7F) when it and every higher digit are 0. Digit 0 is never blanked.
- Segment decode (hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - codes >9 decode to 7F.

Test Plan:
1. Reset:
   - Stimulus: init=1 for 2 cycles, load=0.
   - Response: busy=0, valid=0, bcd=8'h00, an=2'b11, seg=7'h7F, stable while idle.
2. Basic conversion:
   - Stimulus: data=42, load rises.
   - Response: busy=1 for exactly 6 cycles; then bcd=8'h42, valid=1, busy=0.
   - Stimulus: data=63.
   - Response: bcd=8'h63.
3. Zero:
   - Stimulus: data=0.
   - Response: bcd=8'h00; an[1] never low; an=2'b10 shows seg=7'h40.
4. Handshake robustness:
   - Stimulus: data=9, load rises and stays high 20 cycles; data changes to 50 during CONV; a second load pulse arrives mid-CONV.
   - Response: exactly one conversion, result bcd=8'h09.
5. Refresh (REFRESH_DIV=4), bcd=8'h42:
   - Response: an alternates 2'b10 / 2'b01 every 4 cycles, with seg=7'h24 on 2'b10 and seg=7'h19 on 2'b01.
6. Reset mid-conversion:
   - Stimulus: init pulses on the 3rd CONV cycle.
   - Response: next cycle shows all reset values; valid stays 0 until a new load rising edge completes a conversion.
